cv32e40s_obi_responder: RTL and testbench
=========================================

// Module: cv32e40s_obi_responder
// PURPOSE
// - OBI responder (slave end) for the compressed instruction/data OBI interface; answers core-side A-channel
//   requests with gnt, issues accesses to a 1-cycle-latency SRAM port, returns in-order R-channel responses.
// - Used as memory model in core-level benches and as the bridge to tightly-coupled SRAM in small subsystems.
// PARAMETERS
// - ADDR_WIDTH       32        OBI/SRAM address width
// - DATA_WIDTH       32        OBI/SRAM data width (BE width = DATA_WIDTH/8)
// - MAX_OUTSTANDING  2         max granted-but-unanswered transactions (>=1); also response FIFO depth
// - MEM_BASE         'h0       first decoded byte address
// - MEM_SIZE         'h10000   decoded bytes; address outside [MEM_BASE, MEM_BASE+MEM_SIZE) -> error response
// PORTS
// - clk            in   1           clock, all state on rising edge
// - rst            in   1           synchronous reset, active-high
// - obi_req_i      in   1           A-channel request
// - obi_gnt_o      out  1           A-channel grant (combinational from req + state)
// - obi_addr_i     in   ADDR_WIDTH  byte address
// - obi_we_i       in   1           1 = write
// - obi_be_i       in   DATA_WIDTH/8 byte enables
// - obi_wdata_i    in   DATA_WIDTH  write data
// - obi_rvalid_o   out  1           R-channel response valid (exactly 1 cycle per response; no rready)
// - obi_rdata_o    out  DATA_WIDTH  read data (0 for writes and errors)
// - obi_err_o      out  1           bus error for this response
// - gnt_stall_i    in   1           1 = suppress grant this cycle (bench/arbiter backpressure)
// - resp_stall_i   in   1           1 = hold off rvalid this cycle
// - mem_req_o      out  1           SRAM access strobe (combinational)
// - mem_we_o / mem_addr_o / mem_be_o / mem_wdata_o  out  SRAM controls, pass-through of A-channel on grant
// - mem_rdata_i    in   DATA_WIDTH  SRAM read data, valid the cycle after mem_req_o
// BEHAVIOUR
// - Reset: FIFO empty, outstanding count 0, pipe stage invalid; obi_gnt_o, obi_rvalid_o, mem_req_o = 0 while rst;
//   obi_rdata_o = 0, obi_err_o = 0. Reset mid-transaction discards all in-flight responses.
// - Grant: obi_gnt_o = obi_req_i & ~gnt_stall_i & (outstanding < MAX_OUTSTANDING) & ~rst. Transfer = req & gnt.
//   gnt never depends on rvalid of the same cycle (no same-cycle slot reuse).
// - Decode: in_range = addr >= MEM_BASE & addr < MEM_BASE+MEM_SIZE (full-width compare, no wrap).
//   mem_req_o = transfer & in_range; mem_addr_o = addr - MEM_BASE; out-of-range transfer issues no SRAM access.
// - Pipeline: cycle t transfer -> stage reg at t+1 holds {err, we}; at t+1 entry {rdata, err} pushed into FIFO,
//   rdata = mem_rdata_i for in-range reads, 0 otherwise. Earliest obi_rvalid_o at t+2.
// - Response: obi_rvalid_o = ~fifo_empty & ~resp_stall_i; rdata/err driven from FIFO head, 0 when rvalid=0;
//   pop on rvalid. Responses strictly in grant order.
// - Outstanding count: +1 on transfer, -1 on rvalid, unchanged when both; counts pipe stage + FIFO entries, so
//   FIFO can never overflow; push into full FIFO is unreachable (assert).
// - Simultaneous push and pop on same FIFO entry: both take effect; pointers wrap modulo MAX_OUTSTANDING.
// - A-channel inputs sampled only in transfer cycle; change while req=1 & gnt=0 is legal and not checked here.
// TESTING
// - Back-to-back reads, MAX_OUTSTANDING=2, SRAM word at 'h10 = 'hDEADBEEF, 'h14 = 'h12345678 -> gnt at t,t+1,
//   rvalid at t+2,t+3 with those data, err=0.
// - Three consecutive requests, no resp_stall -> third gnt held low until first rvalid has popped (count back to 1).
// - Write 'hCAFEF00D to 'h20 with be='b0011 -> mem_we_o=1, mem_be_o='b0011; response rdata=0 err=0; readback 'h0000F00D
//   from zero-initialised SRAM.
// - Read at MEM_BASE+MEM_SIZE -> mem_req_o stays 0; response err=1 rdata=0 in order between two good reads.
// - resp_stall_i=1 for 5 cycles with 2 outstanding -> no rvalid, gnt=0; release -> two rvalids on consecutive cycles.
// - Assert rst one cycle after a grant -> no rvalid afterwards, count 0, next request granted immediately.

Source files
------------

// File: rtl/cv32e40s_obi_responder_if.sv
// OBI A/R channel bundle between a core-side requester and the responder.
//   master : drives req/addr/we/be/wdata, receives gnt/rvalid/rdata/err
//   slave  : the inverse (used by cv32e40s_obi_responder)
interface cv32e40s_obi_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/cv32e40s_obi_responder.sv
// OBI responder: grants A-channel requests, forwards in-range accesses to a
// 1-cycle-latency SRAM port, and returns responses in grant order.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   obi (slave)       OBI A-channel in, R-channel out
//   gnt_stall_i       suppress grant this cycle
//   resp_stall_i      hold off rvalid this cycle
//   mem_*_o           SRAM strobe and controls (pass-through of A-channel)
//   mem_rdata_i       SRAM read data, valid the cycle after mem_req_o
module cv32e40s_obi_responder #(
  parameter int unsigned     ADDR_WIDTH      = 32,
  parameter int unsigned     DATA_WIDTH      = 32,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter longint unsigned MEM_BASE        = 'h0,
  parameter longint unsigned MEM_SIZE        = 'h10000
) (
  input  logic                      clk,
  input  logic                      rst,
  cv32e40s_obi_responder_if.slave   obi,
  input  logic                      gnt_stall_i,
  input  logic                      resp_stall_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  // One extra bit so BASE+SIZE at the top of the address space does not wrap.
  localparam logic [64:0] LO_LIM = 65'(MEM_BASE);
  localparam logic [64:0] HI_LIM = 65'(MEM_BASE) + 65'(MEM_SIZE);

  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wptr, rptr;
  logic                  stg_vld, stg_err, stg_we;
  logic [DATA_WIDTH-1:0] fifo_rdata [MAX_OUTSTANDING];
  logic                  fifo_err   [MAX_OUTSTANDING];

  logic                  transfer, in_range, push, pop;
  logic [64:0]           addr_ext;
  logic [DATA_WIDTH-1:0] push_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A-channel / decode
  assign addr_ext = 65'(obi.addr);
  assign in_range = (addr_ext >= LO_LIM) && (addr_ext < HI_LIM);
  // Grant looks only at registered count: a slot freed by this cycle's rvalid
  // is reusable next cycle, never the same one.
  assign obi.gnt  = obi.req & ~gnt_stall_i & (outstanding < MAX_CNT) & ~rst;
  assign transfer = obi.req & obi.gnt;

  assign mem_req_o   = transfer & in_range;
  assign mem_we_o    = obi.we;
  assign mem_addr_o  = obi.addr - ADDR_WIDTH'(MEM_BASE);
  assign mem_be_o    = obi.be;
  assign mem_wdata_o = obi.wdata;

  // Response capture: SRAM data only meaningful for in-range reads.
  assign push       = stg_vld;
  assign push_rdata = (!stg_err && !stg_we) ? mem_rdata_i : '0;

  // R-channel
  assign pop        = (fifo_cnt != '0) & ~resp_stall_i & ~rst;
  assign obi.rvalid = pop;
  assign obi.rdata  = pop ? fifo_rdata[rptr] : '0;
  assign obi.err    = pop ? fifo_err[rptr]   : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      fifo_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      stg_vld     <= 1'b0;
      stg_err     <= 1'b0;
      stg_we      <= 1'b0;
    end else begin
      // outstanding covers stage + FIFO, so the FIFO can never overflow
      assert (!(push && !pop && fifo_cnt == MAX_CNT));
      stg_vld <= transfer;
      stg_err <= ~in_range;
      stg_we  <= obi.we;
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({transfer, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_rdata[wptr] <= push_rdata;
      fifo_err[wptr]   <= stg_err;
    end
  end
endmodule

// File: tb/tb_cv32e40s_obi_responder.sv
module tb_cv32e40s_obi_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        gnt_stall_i, resp_stall_i;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk  = 0;
  int n_fail = 0;

  logic [32:0] rq [$];           // {err, rdata} of each observed response
  logic [31:0] sram [0:16383];

  always #5 clk = ~clk;

  cv32e40s_obi_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi ();

  cv32e40s_obi_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2),
    .MEM_BASE('h0), .MEM_SIZE('h10000)
  ) dut (
    .clk(clk), .rst(rst), .obi(obi),
    .gnt_stall_i(gnt_stall_i), .resp_stall_i(resp_stall_i),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // 1-cycle SRAM; garbage on the read port after writes so the responder's zeroing is visible
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= 32'hBAD0_BAD0;
      end else begin
        mem_rdata <= sram[mem_addr[15:2]];
      end
    end
  end

  always @(negedge clk) if (obi.rvalid === 1'b1) rq.push_back({obi.err, obi.rdata});

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    obi.req = r; obi.we = w; obi.addr = a; obi.be = b; obi.wdata = d;
  endtask

  // Hold a request until granted (bounded), return mem_req seen in the grant cycle.
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, output logic mreq);
    logic ok = 1'b0;
    mreq = 1'b0;
    drive(1'b1, w, a, b, d);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (obi.gnt) begin ok = 1'b1; mreq = mem_req; end
      else nxt();
    end
    chk("issue_gnt", 64'(ok), 64'd1);
    nxt();
    obi.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic mr;
    for (int i = 0; i < 16384; i++) sram[i] = '0;
    sram[4] = 32'hDEAD_BEEF;   // 'h10
    sram[5] = 32'h1234_5678;   // 'h14
    mem_rdata = '0;
    rst = 1'b1; gnt_stall_i = 1'b0; resp_stall_i = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    nxt();
    @(negedge clk);
    chk("rst_gnt", 64'(obi.gnt), 0);
    chk("rst_memreq", 64'(mem_req), 0);
    chk("rst_rvalid", 64'(obi.rvalid), 0);
    chk("rst_rdata", 64'(obi.rdata), 0);
    chk("rst_err", 64'(obi.err), 0);
    nxt(); rst = 1'b0; obi.req = 1'b0;
    nxt();

    // back-to-back reads
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    chk("b2b_gnt0", 64'(obi.gnt), 1);
    chk("b2b_memreq0", 64'(mem_req), 1);
    chk("b2b_memaddr0", 64'(mem_addr), 64'h10);
    chk("b2b_rv_t0", 64'(obi.rvalid), 0);
    nxt(); obi.addr = 32'h14;
    @(negedge clk);
    chk("b2b_gnt1", 64'(obi.gnt), 1);
    chk("b2b_rv_t1", 64'(obi.rvalid), 0);
    nxt(); obi.req = 1'b0;
    @(negedge clk);
    chk("b2b_rv_t2", 64'(obi.rvalid), 1);
    chk("b2b_rd_t2", 64'(obi.rdata), 64'hDEADBEEF);
    chk("b2b_err_t2", 64'(obi.err), 0);
    nxt();
    @(negedge clk);
    chk("b2b_rv_t3", 64'(obi.rvalid), 1);
    chk("b2b_rd_t3", 64'(obi.rdata), 64'h12345678);
    nxt();
    @(negedge clk);
    chk("b2b_rv_t4", 64'(obi.rvalid), 0);
    nxt();

    // three requests: third held off until count drops
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk); chk("three_gnt0", 64'(obi.gnt), 1);
    nxt(); obi.addr = 32'h14;
    @(negedge clk); chk("three_gnt1", 64'(obi.gnt), 1);
    nxt(); obi.addr = 32'h10;
    @(negedge clk);
    chk("three_gnt2_blocked", 64'(obi.gnt), 0);
    chk("three_rv_t2", 64'(obi.rvalid), 1);
    nxt();
    @(negedge clk);
    chk("three_gnt3", 64'(obi.gnt), 1);
    chk("three_rd_t3", 64'(obi.rdata), 64'h12345678);
    nxt(); obi.req = 1'b0;
    @(negedge clk); chk("three_rv_t4", 64'(obi.rvalid), 0);
    nxt();
    @(negedge clk);
    chk("three_rv_t5", 64'(obi.rvalid), 1);
    chk("three_rd_t5", 64'(obi.rdata), 64'hDEADBEEF);
    nxt();

    // partial write then readback
    rq.delete();
    drive(1'b1, 1'b1, 32'h20, 4'b0011, 32'hCAFEF00D);
    @(negedge clk);
    chk("wr_gnt", 64'(obi.gnt), 1);
    chk("wr_memreq", 64'(mem_req), 1);
    chk("wr_memwe", 64'(mem_we), 1);
    chk("wr_membe", 64'(mem_be), 64'b0011);
    chk("wr_memwdata", 64'(mem_wdata), 64'hCAFEF00D);
    nxt(); obi.req = 1'b0;
    issue(32'h20, 1'b0, 4'hF, 32'h0, mr);
    repeat (4) nxt();
    chk("wr_nresp", 64'(rq.size()), 2);
    chk("wr_resp", 64'(rq[0]), 64'h0);
    chk("wr_readback", 64'(rq[1]), 64'h0000F00D);

    // out-of-range read between two good reads
    rq.delete();
    issue(32'h10, 1'b0, 4'hF, 32'h0, mr);
    issue(32'h10000, 1'b0, 4'hF, 32'h0, mr);
    chk("oor_memreq", 64'(mr), 0);
    issue(32'h14, 1'b0, 4'hF, 32'h0, mr);
    repeat (5) nxt();
    chk("oor_nresp", 64'(rq.size()), 3);
    chk("oor_r0", 64'(rq[0]), 64'h0DEADBEEF);
    chk("oor_r1", 64'(rq[1]), 64'h100000000);
    chk("oor_r2", 64'(rq[2]), 64'h012345678);

    // response stall with two outstanding
    rq.delete();
    resp_stall_i = 1'b1;
    issue(32'h10, 1'b0, 4'hF, 32'h0, mr);
    issue(32'h14, 1'b0, 4'hF, 32'h0, mr);
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_gnt", 64'(obi.gnt), 0);
      chk("stall_rv", 64'(obi.rvalid), 0);
      nxt();
    end
    obi.req = 1'b0; resp_stall_i = 1'b0;
    @(negedge clk);
    chk("rel_rv0", 64'(obi.rvalid), 1);
    chk("rel_rd0", 64'(obi.rdata), 64'hDEADBEEF);
    nxt();
    @(negedge clk);
    chk("rel_rv1", 64'(obi.rvalid), 1);
    chk("rel_rd1", 64'(obi.rdata), 64'h12345678);
    nxt();
    @(negedge clk);
    chk("rel_rv2", 64'(obi.rvalid), 0);
    nxt();

    // reset one cycle after a grant
    rq.delete();
    issue(32'h10, 1'b0, 4'hF, 32'h0, mr);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
    @(negedge clk);
    chk("mrst_gnt", 64'(obi.gnt), 0);
    chk("mrst_memreq", 64'(mem_req), 0);
    chk("mrst_rv", 64'(obi.rvalid), 0);
    nxt(); rst = 1'b0;
    @(negedge clk);
    chk("mrst_gnt_after", 64'(obi.gnt), 1);
    nxt(); obi.req = 1'b0;
    repeat (5) nxt();
    chk("mrst_nresp", 64'(rq.size()), 1);
    chk("mrst_r0", 64'(rq[0]), 64'h012345678);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
